data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single-port data RAM between NUM_M bus masters: master 0 is the CPU load/store port, masters 1..3 are the UART A/B/C receive-DMA engines.
- Grants access per cycle using round-robin, with optional fixed CPU priority and bounded burst locking.
- Read data from the RAM is steered back with one-cycle latency.
- Sits in top_v1 between the masters and the data memory.

Parameters:
- NUM_M, 4, number of masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- CPU_PRIO, 1, 1 = master 0 wins whenever it requests; 0 = pure round-robin.
- MAX_BURST, 4, maximum consecutive grants a locking master may hold (1..15).

Ports:
- clk_100m_i  in  1  system clock, 100 MHz.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_M  per-master access request.
- lock_i  in  NUM_M  per-master burst-lock request.
- we_i  in  NUM_M  per-master write enable (1 = write).
- addr_i  in  NUM_M*ADDR_W  packed addresses; master k is at [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_M*DATA_W  packed write data.
- gnt_o  out  NUM_M  one-hot grant, combinational, same cycle.
- rvalid_o  out  NUM_M  one-hot read-data-valid, registered.
- rdata_o  out  DATA_W  read data, valid while any rvalid_o bit is high.
- mem_en_o  out  1  RAM access enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_rdata_i  in  DATA_W  RAM read data, one cycle after mem_en_o.

Behaviour:
- Clock and reset: clk_100m_i is the only clock. rst_i is synchronous and active-high.
- Reset values:
  - rr_ptr = 0, owner = none, burst_cnt = 0.
  - rvalid_o = 0, rdata_o = 0.
  - gnt_o = 0 and mem_en_o = mem_we_o = 0 in the reset cycle, regardless of req_i.
- Handshake: a master asserts req_i and holds we_i/addr_i/wdata_i stable until it sees gnt_o high. The transfer completes in the grant cycle. The master drops req_i or presents its next request in the following cycle.
- Winner selection each cycle, in priority order:
  1. Lock owner: if owner is valid, req_i[owner] = 1, lock_i[owner] = 1 and burst_cnt < MAX_BURST, the owner wins.
  2. CPU priority: else, if CPU_PRIO = 1 and req_i[0] = 1, master 0 wins.
  3. Round-robin: else, the first requesting master scanning rr_ptr, rr_ptr+1, ... modulo NUM_M wins.
  4. If nothing is requesting, there is no winner.
- Datapath on a winner w:
  - gnt_o[w] = 1.
  - mem_en_o = 1, mem_we_o = we_i[w].
  - mem_addr_o and mem_wdata_o are master w's slices.
- Datapath with no winner: gnt_o = 0, mem_en_o = 0, mem_we_o = 0. mem_addr_o and mem_wdata_o are 0.
- Pointer update: on any grant, rr_ptr <= (w+1) mod NUM_M. The CPU-priority path also advances the pointer.
- Burst lock:
  - Start: a grant to w with lock_i[w] = 1 sets owner <= w. It also sets burst_cnt <= 1 if w is a new owner, or burst_cnt + 1 if w is already the owner.
  - Release: owner is released (none, burst_cnt = 0) when any of the following holds:
    - a grant with lock_i[w] = 0;
    - owner not requesting;
    - burst_cnt reaches MAX_BURST, forced release.
  - After a forced release, the next grant is arbitrated normally; the ex-owner is not excluded.
  - Lock overrides CPU_PRIO. The CPU therefore waits at most MAX_BURST cycles.
- Read return: a granted read (we = 0) sets rvalid_o[w] = 1 in the next cycle with rdata_o = mem_rdata_i. Otherwise rvalid_o = 0 and rdata_o holds its last value.
- Back-to-back reads by different masters each return in their own cycle, in grant order, with no bubbles.
- Writes produce no rvalid_o.
- Simultaneous events: at most one gnt_o and one rvalid_o bit is ever high. Grant and rvalid_o may be high for different masters in the same cycle.
- Reset mid-operation: a read granted in the cycle rst_i rises returns no rvalid_o. Lock and rr_ptr are cleared.
- Invalid inputs: lock_i without req_i is ignored.

Test Plan:
- Reset: hold rst_i = 1 with req_i = 4'b1111 -> gnt_o = 0, mem_en_o = 0, rvalid_o = 0. First cycle after release with CPU_PRIO = 1 -> gnt_o = 4'b0001.
- Round-robin: CPU_PRIO = 0, req_i = 4'b1110 held, each master dropping req for one cycle after its grant -> grants go 1, 2, 3, 1, 2; no master is granted twice before the others.
- CPU priority: CPU_PRIO = 1, master 2 requesting, CPU requests in cycle 3 -> gnt_o = 4'b0001 in cycle 3; master 2 is granted in cycle 4 once the CPU drops req.
- Burst lock: master 3 asserts req + lock continuously with the CPU also requesting -> master 3 is granted 4 consecutive cycles (MAX_BURST = 4), then master 0 is granted in the 5th cycle.
- Read return: master 1 writes 0xDEADBEEF to 0x100, then master 2 reads 0x100 -> rvalid_o = 4'b0100 one cycle after the read grant with rdata_o = 0xDEADBEEF; no rvalid_o follows the write.
- Reset mid-burst: rst_i pulsed during master 3's locked burst with a read pending -> no rvalid_o, owner cleared, next grant follows rr_ptr = 0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares one single-port data RAM between NUM_M bus masters (master 0 = CPU,
//   masters 1..NUM_M-1 = receive-DMA engines). One grant per cycle: an active
//   burst-lock owner wins first, then the CPU (when CPU_PRIO = 1), then
//   round-robin from rr_ptr. Read data returns one cycle after the grant.
//
// Ports
//   clk_100m_i   system clock
//   rst_i        synchronous active-high reset
//   req_i        per-master request
//   lock_i       per-master burst-lock request
//   we_i         per-master write enable
//   addr_i       packed per-master addresses, master k at [k*ADDR_W +: ADDR_W]
//   wdata_i      packed per-master write data
//   gnt_o        one-hot grant, combinational
//   rvalid_o     one-hot read-data-valid, registered
//   rdata_o      read data, valid while any rvalid_o bit is high, else holds
//   mem_*_o      RAM access port (en, we, addr, wdata)
//   mem_rdata_i  RAM read data, one cycle after mem_en_o

// Per-master slot: gates the master's request fields onto the shared bus when
// granted and registers that master's read-valid bit.
module data_bus_arbiter_slot #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gnt,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              sel_we,
   output logic [ADDR_W-1:0] sel_addr,
   output logic [DATA_W-1:0] sel_wdata,
   output logic              rvalid
);
   assign sel_we    = gnt & we;
   assign sel_addr  = gnt ? addr  : '0;
   assign sel_wdata = gnt ? wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) rvalid <= 1'b0;
      else     rvalid <= gnt & ~we;
   end
endmodule

module data_bus_arbiter #(
   parameter int NUM_M     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int CPU_PRIO  = 1,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk_100m_i,
   input  logic                    rst_i,
   input  logic [NUM_M-1:0]        req_i,
   input  logic [NUM_M-1:0]        lock_i,
   input  logic [NUM_M-1:0]        we_i,
   input  logic [NUM_M*ADDR_W-1:0] addr_i,
   input  logic [NUM_M*DATA_W-1:0] wdata_i,
   output logic [NUM_M-1:0]        gnt_o,
   output logic [NUM_M-1:0]        rvalid_o,
   output logic [DATA_W-1:0]       rdata_o,
   output logic                    mem_en_o,
   output logic                    mem_we_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic [DATA_W-1:0]       mem_wdata_o,
   input  logic [DATA_W-1:0]       mem_rdata_i
);
   localparam int PTR_W  = $clog2(NUM_M);
   localparam int PTR_W1 = PTR_W + 1;
   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   logic [NUM_M-1:0][ADDR_W-1:0] addr_v, sel_addr;
   logic [NUM_M-1:0][DATA_W-1:0] wdata_v, sel_wdata;
   logic [NUM_M-1:0]             sel_we, gnt;

   logic [PTR_W-1:0]  rr_ptr, owner, win;
   logic              owner_vld, win_vld, lock_hit;
   logic [3:0]        burst_cnt, cnt_next;
   logic [PTR_W1-1:0] idx;
   logic              rd_pend;
   logic [DATA_W-1:0] rdata_q;

   assign addr_v  = addr_i;
   assign wdata_v = wdata_i;

   // Owner keeps the bus only while it still requests with lock and has
   // burst budget left.
   assign lock_hit = owner_vld && req_i[owner] && lock_i[owner] && (burst_cnt < MAX_B);

   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      if (!rst_i) begin
         if (lock_hit) begin
            win_vld = 1'b1;
            win     = owner;
         end else if (CPU_PRIO != 0 && req_i[0]) begin
            win_vld = 1'b1;
            win     = '0;
         end else begin
            for (int i = 0; i < NUM_M; i++) begin
               // rr_ptr + i modulo NUM_M without a divider
               idx = {1'b0, rr_ptr} + PTR_W1'(i);
               if (idx >= PTR_W1'(NUM_M)) idx = idx - PTR_W1'(NUM_M);
               if (!win_vld && req_i[idx[PTR_W-1:0]]) begin
                  win_vld = 1'b1;
                  win     = idx[PTR_W-1:0];
               end
            end
         end
      end
   end

   assign gnt   = win_vld ? (NUM_M'(1) << win) : '0;
   assign gnt_o = gnt;

   for (genvar k = 0; k < NUM_M; k++) begin : g_slot
      data_bus_arbiter_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
         .clk      (clk_100m_i),
         .rst      (rst_i),
         .gnt      (gnt[k]),
         .we       (we_i[k]),
         .addr     (addr_v[k]),
         .wdata    (wdata_v[k]),
         .sel_we   (sel_we[k]),
         .sel_addr (sel_addr[k]),
         .sel_wdata(sel_wdata[k]),
         .rvalid   (rvalid_o[k])
      );
   end

   // Slots zero their fields when not granted, so an OR tree is the mux.
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      for (int k = 0; k < NUM_M; k++) begin
         mem_addr_o  = mem_addr_o  | sel_addr[k];
         mem_wdata_o = mem_wdata_o | sel_wdata[k];
      end
   end

   assign mem_en_o = win_vld;
   assign mem_we_o = |sel_we;

   // Continuing owner extends its burst; any other locking winner starts anew.
   assign cnt_next = (owner_vld && owner == win) ? burst_cnt + 4'd1 : 4'd1;

   always_ff @(posedge clk_100m_i) begin
      if (rst_i) begin
         rr_ptr    <= '0;
         owner_vld <= 1'b0;
         owner     <= '0;
         burst_cnt <= '0;
      end else if (win_vld) begin
         rr_ptr <= (win == PTR_W'(NUM_M - 1)) ? '0 : win + PTR_W'(1);
         if (lock_i[win] && cnt_next < MAX_B) begin
            owner_vld <= 1'b1;
            owner     <= win;
            burst_cnt <= cnt_next;
         end else begin
            // unlocked grant, or the burst just used its last slot
            owner_vld <= 1'b0;
            owner     <= '0;
            burst_cnt <= '0;
         end
      end else if (owner_vld && !req_i[owner]) begin
         owner_vld <= 1'b0;
         owner     <= '0;
         burst_cnt <= '0;
      end
   end

   // RAM data arrives in the rvalid cycle, so it is passed straight through
   // then and captured to hold rdata_o steady afterwards.
   assign rd_pend = |rvalid_o;
   assign rdata_o = rd_pend ? mem_rdata_i : rdata_q;

   always_ff @(posedge clk_100m_i) begin
      if (rst_i)        rdata_q <= '0;
      else if (rd_pend) rdata_q <= mem_rdata_i;
   end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: table of per-cycle vectors plus hand-written
// read-return and reset-mid-burst sequences. Read results go through a
// scoreboard queue keyed by the cycle they are due.
module tb_data_bus_arbiter;
   localparam int NM = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NM-1:0]    req = '0, lock = '0, we = '0;
   logic [NM*32-1:0] addr = '0, wdata = '0;
   logic [NM-1:0]    gnt, rvalid;
   logic [31:0]      rdata, mem_addr, mem_wdata;
   logic             mem_en, mem_we;
   logic [31:0]      ram_q = '0;

   logic [NM-1:0]    rr_gnt, rr_rvalid;
   logic [31:0]      rr_rdata, rr_addr, rr_wdata;
   logic             rr_en, rr_we;

   always #5 clk = ~clk;

   data_bus_arbiter #(.NUM_M(NM), .ADDR_W(32), .DATA_W(32), .CPU_PRIO(1), .MAX_BURST(4)) dut (
      .clk_100m_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(ram_q));

   // Pure round-robin variant on the same inputs; only its grants are checked.
   data_bus_arbiter #(.NUM_M(NM), .ADDR_W(32), .DATA_W(32), .CPU_PRIO(0), .MAX_BURST(4)) dut_rr (
      .clk_100m_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(rr_gnt), .rvalid_o(rr_rvalid), .rdata_o(rr_rdata),
      .mem_en_o(rr_en), .mem_we_o(rr_we), .mem_addr_o(rr_addr),
      .mem_wdata_o(rr_wdata), .mem_rdata_i(ram_q));

   // RAM model attached to the main instance
   logic [31:0] ram [logic [31:0]];
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      else if (mem_en) ram_q <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
   end

   // Expected memory contents, updated from the bench's own expected grants
   logic [31:0] shadow [logic [31:0]];
   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : 32'h0;
   endfunction

   typedef struct { logic [3:0] mask; logic [31:0] data; int due; } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic check_rv(input string nm);
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk({nm, " rvalid"}, 32'(rvalid), 32'(e.mask));
         chk({nm, " rdata"}, rdata, e.data);
         last_rd = e.data;
      end else begin
         chk({nm, " no_rvalid"}, 32'(rvalid), 32'h0);
         chk({nm, " rdata_hold"}, rdata, last_rd);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [3:0] w, input logic [3:0][31:0] a,
                       input logic [3:0][31:0] d, input logic [3:0] eg,
                       input logic crr, input logic [3:0] egr, input string nm);
      int   wi;
      exp_t e;
      rst = r; req = rq; lock = lk; we = w; addr = a; wdata = d;
      @(negedge clk);
      wi = 0;
      for (int k = 0; k < NM; k++) if (eg[k]) wi = k;
      chk({nm, " gnt"}, 32'(gnt), 32'(eg));
      chk({nm, " mem_en"}, 32'(mem_en), 32'(|eg));
      chk({nm, " mem_we"}, 32'(mem_we), 32'(|(eg & w)));
      chk({nm, " mem_addr"}, mem_addr, (eg != 0) ? a[wi] : 32'h0);
      chk({nm, " mem_wdata"}, mem_wdata, (eg != 0) ? d[wi] : 32'h0);
      if (crr) chk({nm, " rr_gnt"}, 32'(rr_gnt), 32'(egr));
      if (eg != 0) begin
         if (w[wi]) shadow[a[wi]] = d[wi];
         else begin
            e.mask = eg; e.data = shadow_rd(a[wi]); e.due = cyc + 1;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (r) last_rd = '0;
      check_rv(nm);
   endtask

   typedef struct {
      logic rst; logic [3:0] req, lock, we; logic [31:0] abase, dbase;
      logic [3:0] eg; logic crr; logic [3:0] egr;
   } vec_t;
   vec_t tbl[25];

   logic [3:0][31:0] ha, hd;

   initial begin
      //          rst   req      lock     we       abase     dbase          eg       crr   egr
      tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h000, 32'h0,         4'b0000, 1'b1, 4'b0000};
      tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 32'h000, 32'h0,         4'b0000, 1'b1, 4'b0000};
      tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 32'h000, 32'h0,         4'b0001, 1'b1, 4'b0001};
      tbl[3]  = '{1'b0, 4'b1110, 4'b0000, 4'b1110, 32'h100, 32'hA5A50000, 4'b0010, 1'b1, 4'b0010};
      tbl[4]  = '{1'b0, 4'b1100, 4'b0000, 4'b1110, 32'h100, 32'hA5A50000, 4'b0100, 1'b1, 4'b0100};
      tbl[5]  = '{1'b0, 4'b1010, 4'b0000, 4'b1110, 32'h100, 32'hA5A50000, 4'b1000, 1'b1, 4'b1000};
      tbl[6]  = '{1'b0, 4'b0110, 4'b0000, 4'b0000, 32'h100, 32'h0,         4'b0010, 1'b1, 4'b0010};
      tbl[7]  = '{1'b0, 4'b1100, 4'b0000, 4'b0000, 32'h100, 32'h0,         4'b0100, 1'b1, 4'b0100};
      tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 32'h200, 32'h11110000, 4'b0100, 1'b1, 4'b0100};
      tbl[9]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h200, 32'h0,         4'b0100, 1'b1, 4'b0100};
      tbl[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 32'h200, 32'h0,         4'b0001, 1'b1, 4'b0001};
      tbl[11] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 32'h200, 32'h0,         4'b0001, 1'b1, 4'b0100};
      tbl[12] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h200, 32'h0,         4'b0100, 1'b1, 4'b0100};
      tbl[13] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b1000, 1'b1, 4'b1000};
      tbl[14] = '{1'b0, 4'b1001, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b1000, 1'b1, 4'b1000};
      tbl[15] = '{1'b0, 4'b1001, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b1000, 1'b1, 4'b1000};
      tbl[16] = '{1'b0, 4'b1001, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b1000, 1'b1, 4'b1000};
      tbl[17] = '{1'b0, 4'b1001, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b0001, 1'b1, 4'b0001};
      tbl[18] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 32'h100, 32'h0,         4'b1000, 1'b1, 4'b1000};
      tbl[19] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 32'h100, 32'h0,         4'b0001, 1'b1, 4'b0001};
      tbl[20] = '{1'b0, 4'b0010, 4'b0100, 4'b0000, 32'h100, 32'h0,         4'b0010, 1'b1, 4'b0010};
      tbl[21] = '{1'b0, 4'b0110, 4'b0110, 4'b0000, 32'h100, 32'h0,         4'b0100, 1'b1, 4'b0100};
      tbl[22] = '{1'b0, 4'b0011, 4'b0100, 4'b0000, 32'h100, 32'h0,         4'b0001, 1'b1, 4'b0001};
      tbl[23] = '{1'b0, 4'b0110, 4'b0100, 4'b0000, 32'h100, 32'h0,         4'b0010, 1'b1, 4'b0010};
      tbl[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h100, 32'h0,         4'b0000, 1'b1, 4'b0000};

      for (int i = 0; i < 25; i++) begin
         for (int k = 0; k < NM; k++) begin
            ha[k] = tbl[i].abase + 32'(k * 16);
            hd[k] = tbl[i].dbase + 32'(k);
         end
         step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].we, ha, hd,
              tbl[i].eg, tbl[i].crr, tbl[i].egr, $sformatf("vec%0d", i));
      end

      // Read return: master 1 writes, master 2 reads back, then back-to-back
      // reads by masters 0 and 1.
      ha = '0; hd = '0; ha[1] = 32'h100; hd[1] = 32'hDEADBEEF;
      step(1'b0, 4'b0010, 4'b0000, 4'b0010, ha, hd, 4'b0010, 1'b0, 4'b0, "rd_wr");
      ha = '0; hd = '0; ha[2] = 32'h100;
      step(1'b0, 4'b0100, 4'b0000, 4'b0000, ha, hd, 4'b0100, 1'b0, 4'b0, "rd_rd2");
      ha = '0; ha[0] = 32'h100; ha[1] = 32'h110;
      step(1'b0, 4'b0011, 4'b0000, 4'b0000, ha, hd, 4'b0001, 1'b0, 4'b0, "rd_rd0");
      step(1'b0, 4'b0010, 4'b0000, 4'b0000, ha, hd, 4'b0010, 1'b0, 4'b0, "rd_rd1");

      // Reset in the middle of master 3's locked read burst
      ha = '0; ha[1] = 32'h110; ha[3] = 32'h130;
      step(1'b0, 4'b1000, 4'b1000, 4'b0000, ha, hd, 4'b1000, 1'b0, 4'b0, "rb_b1");
      step(1'b0, 4'b1000, 4'b1000, 4'b0000, ha, hd, 4'b1000, 1'b0, 4'b0, "rb_b2");
      step(1'b1, 4'b1001, 4'b1000, 4'b0000, ha, hd, 4'b0000, 1'b0, 4'b0, "rb_rst");
      chk("rb rdata_reset", rdata, 32'h0);
      step(1'b0, 4'b1010, 4'b1000, 4'b0000, ha, hd, 4'b0010, 1'b1, 4'b0010, "rb_after");
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, ha, hd, 4'b0000, 1'b0, 4'b0, "rb_idle");

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
